// File: rtl/occ_cfg_pkg.sv
// Host address map, CTRL bit positions and sweep FSM encoding for the occupancy table responder.
// Shared by the table responder top and its bench-facing readback logic.
package occ_cfg_pkg;

    localparam logic [7:0] ADDR_INDEX  = 8'h7F;
    localparam logic [7:0] ADDR_CTRL   = 8'h80;
    localparam logic [7:0] ADDR_LIMIT  = 8'h81;
    localparam logic [7:0] ADDR_DWELL0 = 8'h84;
    localparam logic [7:0] ADDR_DWELL1 = 8'h85;
    localparam logic [7:0] ADDR_DWELL2 = 8'h86;
    localparam logic [7:0] ADDR_STATUS = 8'h88;

    localparam int CTRL_SWEEP_EN = 0;
    localparam int CTRL_WRAP     = 1;
    localparam int CTRL_START    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/occ_dpram.sv
// Occupancy table RAM: port A host read/write, port B simulator read; outputs registered and held between reads.
// Latency 1 cycle, read-old-data when a write and read hit the same word; no backpressure, every access completes.
module occ_dpram #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 7,
    parameter int DEPTH     = 127,
    parameter     INIT_MEM  = "occ_table.mif"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic                 a_we,
    input  logic [DATA_BITS-1:0] a_wdata,
    input  logic                 a_rd,
    output logic [DATA_BITS-1:0] a_q,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic                 b_rd,
    output logic [DATA_BITS-1:0] b_q
);

    (* ram_init_file = INIT_MEM *) logic [DATA_BITS-1:0] mem [0:DEPTH-1];

    // Initial contents are attached through the ram_init_file attribute; no logic is needed without a file name.
    if ($bits(INIT_MEM) == 0) begin : g_no_init_file
    end

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    // Only the output registers are cleared; the array keeps its contents across reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (a_rd) begin
                a_q <= mem[a_addr];
            end
            if (b_rd) begin
                b_q <= mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/occ_table_responder.sv
// Occupancy table/index responder with host register port and an optional automatic index sweep.
// Latency: sim and host reads return 1 cycle after the strobe; no backpressure, every access completes.
module occ_table_responder
    import occ_cfg_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int DWELL_BITS = 24,
    parameter     INIT_MEM   = "occ_table.mif",
    parameter int IDX_MAX    = 126
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           host_addr,
    input  logic                 host_write,
    input  logic [DATA_BITS-1:0] host_writedata,
    input  logic                 host_read,
    output logic [DATA_BITS-1:0] host_readdata,
    output logic                 host_rvalid,
    input  logic [6:0]           ram_addr,
    input  logic                 ram_read,
    output logic [DATA_BITS-1:0] ram_rdata,
    output logic [6:0]           cur_index,
    output logic                 sweep_done
);

    localparam logic [6:0] LIMIT_MAX = 7'(IDX_MAX);
    localparam logic [6:0] IDX_ADDR  = ADDR_INDEX[6:0];

    sweep_state_t          state, state_nxt;
    logic [6:0]            index;
    logic [6:0]            limit;
    logic                  sweep_en;
    logic                  wrap;
    logic [DWELL_BITS-1:0] dwell;
    logic [DWELL_BITS-1:0] dwell_cnt;
    logic                  step;

    logic                  host_tbl;
    logic                  idx_wr;
    logic                  ctrl_wr;
    logic                  start;
    logic                  en_nxt;
    logic                  at_limit;
    logic [DATA_BITS-1:0]  reg_rdata;

    logic                  host_tbl_q;
    logic [DATA_BITS-1:0]  host_reg_q;
    logic                  sim_idx_sel_q;
    logic [6:0]            sim_idx_q;
    logic [DATA_BITS-1:0]  ram_q_a;
    logic [DATA_BITS-1:0]  ram_q_b;

    assign host_tbl = ~host_addr[7] && (host_addr[6:0] != IDX_ADDR);
    assign idx_wr   = host_write && (host_addr == ADDR_INDEX);
    assign ctrl_wr  = host_write && (host_addr == ADDR_CTRL);
    assign start    = ctrl_wr && host_writedata[CTRL_START];
    assign en_nxt   = ctrl_wr ? host_writedata[CTRL_SWEEP_EN] : sweep_en;
    assign at_limit = index >= limit;

    occ_dpram #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (7),
        .DEPTH     (IDX_MAX + 1),
        .INIT_MEM  (INIT_MEM)
    ) u_dpram (
        .clk     (clk),
        .rst     (rst),
        .a_addr  (host_addr[6:0]),
        .a_we    (host_write && host_tbl),
        .a_wdata (host_writedata),
        .a_rd    (host_read && host_tbl),
        .a_q     (ram_q_a),
        .b_addr  (ram_addr),
        .b_rd    (ram_read && (ram_addr != IDX_ADDR)),
        .b_q     (ram_q_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A host index write in the same cycle as a due step wins and suppresses the step.
    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        if (!en_nxt) begin
            state_nxt = ST_IDLE;
        end else if (start) begin
            state_nxt = ST_RUN;
        end else if (state == ST_RUN && dwell_cnt == dwell && !idx_wr) begin
            step = 1'b1;
            if (at_limit && !wrap) begin
                state_nxt = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index      <= '0;
            limit      <= LIMIT_MAX;
            sweep_en   <= 1'b0;
            wrap       <= 1'b0;
            dwell      <= '0;
            dwell_cnt  <= '0;
            sweep_done <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                sweep_en <= host_writedata[CTRL_SWEEP_EN];
                wrap     <= host_writedata[CTRL_WRAP];
            end
            if (host_write && host_addr == ADDR_LIMIT) begin
                limit <= (host_writedata > DATA_BITS'(IDX_MAX)) ? LIMIT_MAX : host_writedata[6:0];
            end
            if (host_write && host_addr == ADDR_DWELL0) dwell[7:0]   <= host_writedata[7:0];
            if (host_write && host_addr == ADDR_DWELL1) dwell[15:8]  <= host_writedata[7:0];
            if (host_write && host_addr == ADDR_DWELL2) dwell[23:16] <= host_writedata[7:0];

            if (idx_wr) begin
                index      <= host_writedata[6:0];
                dwell_cnt  <= '0;
                sweep_done <= 1'b0;
            end else if (start) begin
                index      <= '0;
                dwell_cnt  <= '0;
                sweep_done <= 1'b0;
            end else if (step) begin
                dwell_cnt <= '0;
                if (!at_limit) begin
                    index <= index + 7'd1;
                end else if (wrap) begin
                    index <= '0;
                end else begin
                    sweep_done <= 1'b1;
                end
            end else if (state == ST_RUN && state_nxt == ST_RUN) begin
                dwell_cnt <= dwell_cnt + DWELL_BITS'(1);
            end else begin
                dwell_cnt <= '0;
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (host_addr)
            ADDR_INDEX:  reg_rdata = {1'b0, index};
            ADDR_CTRL:   reg_rdata = {6'b0, wrap, sweep_en};
            ADDR_LIMIT:  reg_rdata = {1'b0, limit};
            ADDR_DWELL0: reg_rdata = dwell[7:0];
            ADDR_DWELL1: reg_rdata = dwell[15:8];
            ADDR_DWELL2: reg_rdata = dwell[23:16];
            ADDR_STATUS: reg_rdata = {6'b0, sweep_done, state == ST_RUN};
            default:     reg_rdata = '0;
        endcase
    end

    // Register values are captured at the strobe so they line up with the RAM's registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rvalid   <= 1'b0;
            host_tbl_q    <= 1'b0;
            host_reg_q    <= '0;
            sim_idx_sel_q <= 1'b0;
            sim_idx_q     <= '0;
        end else begin
            host_rvalid <= host_read;
            if (host_read) begin
                host_tbl_q <= host_tbl;
                host_reg_q <= reg_rdata;
            end
            if (ram_read) begin
                sim_idx_sel_q <= (ram_addr == IDX_ADDR);
                sim_idx_q     <= index;
            end
        end
    end

    assign host_readdata = host_tbl_q ? ram_q_a : host_reg_q;
    assign ram_rdata     = sim_idx_sel_q ? {1'b0, sim_idx_q} : ram_q_b;
    assign cur_index     = index;

endmodule

// File: tb/tb_occ_table_responder.sv
// Directed bench for occ_table_responder: a cycle-indexed behavioural model predicts every output each cycle.
// Sweep position is derived arithmetically from elapsed cycles since START, not from a dwell counter.
module tb_occ_table_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] host_addr;
    logic       host_write;
    logic [7:0] host_writedata;
    logic       host_read;
    logic [7:0] host_readdata;
    logic       host_rvalid;
    logic [6:0] ram_addr;
    logic       ram_read;
    logic [7:0] ram_rdata;
    logic [6:0] cur_index;
    logic       sweep_done;

    occ_table_responder dut (
        .clk            (clk),
        .rst            (rst),
        .host_addr      (host_addr),
        .host_write     (host_write),
        .host_writedata (host_writedata),
        .host_read      (host_read),
        .host_readdata  (host_readdata),
        .host_rvalid    (host_rvalid),
        .ram_addr       (ram_addr),
        .ram_read       (ram_read),
        .ram_rdata      (ram_rdata),
        .cur_index      (cur_index),
        .sweep_done     (sweep_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_t;

    rd_t        hq[$];
    rd_t        sq[$];
    logic [7:0] exp_ram;

    // Model state
    logic [7:0] tbl_m [0:126];
    logic [6:0] m_idx;
    bit         m_done;
    bit         m_sweeping;
    bit         m_en;
    bit         m_wrap;
    int         m_limit;
    int         m_dwell;
    int         m_start;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_idx      = '0;
        m_done     = 1'b0;
        m_sweeping = 1'b0;
        m_en       = 1'b0;
        m_wrap     = 1'b0;
        m_limit    = 126;
        m_dwell    = 0;
        m_start    = 0;
        exp_ram    = 8'h00;
        hq.delete();
        sq.delete();
    endtask

    function automatic int steps_now();
        return (cyc - m_start) / (m_dwell + 1);
    endfunction

    function automatic logic [6:0] exp_index();
        int s;
        if (!m_sweeping) return m_idx;
        s = steps_now();
        if (m_wrap) return 7'(s % (m_limit + 1));
        return 7'((s > m_limit) ? m_limit : s);
    endfunction

    function automatic bit exp_done();
        if (!m_sweeping) return m_done;
        return !m_wrap && (steps_now() > m_limit);
    endfunction

    function automatic bit exp_run();
        return m_sweeping && !exp_done();
    endfunction

    function automatic logic [7:0] host_model(input logic [7:0] a);
        if (a < 8'h7F) return tbl_m[a[6:0]];
        case (a)
            8'h7F:   return {1'b0, exp_index()};
            8'h80:   return {6'b0, m_wrap, m_en};
            8'h81:   return 8'(m_limit);
            8'h84:   return 8'(m_dwell);
            8'h85:   return 8'(m_dwell >> 8);
            8'h86:   return 8'(m_dwell >> 16);
            8'h88:   return {6'b0, exp_done(), exp_run()};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] sim_model(input logic [6:0] a);
        if (a == 7'h7F) return {1'b0, exp_index()};
        return tbl_m[a];
    endfunction

    // Applied just after the clock edge that commits the write.
    task automatic model_write(input logic [7:0] a, input logic [7:0] d,
                               input logic [6:0] frz_idx, input bit frz_done);
        if (a < 8'h7F) begin
            tbl_m[a[6:0]] = d;
        end else begin
            case (a)
                8'h7F: begin
                    m_sweeping = 1'b0;
                    m_idx      = d[6:0];
                    m_done     = 1'b0;
                end
                8'h80: begin
                    m_en   = d[0];
                    m_wrap = d[1];
                    if (d[2]) begin
                        m_idx      = '0;
                        m_done     = 1'b0;
                        m_sweeping = d[0];
                        m_start    = cyc;
                    end else if (!d[0]) begin
                        m_sweeping = 1'b0;
                        m_idx      = frz_idx;
                        m_done     = frz_done;
                    end
                end
                8'h81: m_limit = (d > 8'd126) ? 126 : int'(d);
                8'h84: m_dwell = (m_dwell & 32'hFFFF00) | int'(d);
                8'h85: m_dwell = (m_dwell & 32'hFF00FF) | (int'(d) << 8);
                8'h86: m_dwell = (m_dwell & 32'h00FFFF) | (int'(d) << 16);
                default: ;
            endcase
        end
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic cycle_op(input logic hw, input logic hr, input logic [7:0] ha, input logic [7:0] hd,
                            input logic rr, input logic [6:0] ra);
        rd_t        e;
        logic [6:0] frz_idx;
        bit         frz_done;
        host_write     = hw;
        host_read      = hr;
        host_addr      = ha;
        host_writedata = hd;
        ram_read       = rr;
        ram_addr       = ra;
        if (hr) begin
            e.due  = cyc + 1;
            e.data = host_model(ha);
            hq.push_back(e);
        end
        if (rr) begin
            e.due  = cyc + 1;
            e.data = sim_model(ra);
            sq.push_back(e);
        end
        frz_idx  = exp_index();
        frz_done = exp_done();
        @(posedge clk);
        #1;
        host_write = 1'b0;
        host_read  = 1'b0;
        ram_read   = 1'b0;
        if (hw) model_write(ha, hd, frz_idx, frz_done);
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        cycle_op(1'b1, 1'b0, a, d, 1'b0, 7'h00);
    endtask

    task automatic host_rd(input logic [7:0] a);
        cycle_op(1'b0, 1'b1, a, 8'h00, 1'b0, 7'h00);
    endtask

    task automatic sim_rd(input logic [6:0] a);
        cycle_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, a);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : compare
        rd_t e;
        if (chk_en) begin
            check("cur_index", cur_index, exp_index());
            check("sweep_done", sweep_done, exp_done());
            if (hq.size() > 0 && hq[0].due == cyc) begin
                e = hq.pop_front();
                check("host_rvalid", host_rvalid, 1'b1);
                check("host_readdata", host_readdata, e.data);
            end else begin
                check("host_rvalid_idle", host_rvalid, 1'b0);
            end
            if (sq.size() > 0 && sq[0].due == cyc) begin
                e = sq.pop_front();
                exp_ram = e.data;
            end
            check("ram_rdata", ram_rdata, exp_ram);
        end
    end

    initial begin
        rst            = 1'b1;
        host_addr      = 8'h00;
        host_write     = 1'b0;
        host_writedata = 8'h00;
        host_read      = 1'b0;
        ram_addr       = 7'h00;
        ram_read       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        check("rst_host_rvalid", host_rvalid, 1'b0);
        check("rst_host_readdata", host_readdata, 8'h00);
        check("rst_ram_rdata", ram_rdata, 8'h00);
        check("rst_cur_index", cur_index, 7'h00);
        check("rst_sweep_done", sweep_done, 1'b0);

        // Idle reads of reset values, LIMIT clamp, unmapped address
        sim_rd(7'h7F);          check("t1_sim_index", ram_rdata, 8'h00);
        host_rd(8'h81);         check("t1_limit", host_readdata, 8'd126);
        host_rd(8'h88);         check("t1_status", host_readdata, 8'h00);
        host_wr(8'h81, 8'd200);
        host_rd(8'h81);         check("t1_limit_clamp", host_readdata, 8'd126);
        host_wr(8'h83, 8'hFF);
        host_rd(8'h83);         check("t1_unmapped", host_readdata, 8'h00);

        // Table and index through the sim port
        host_wr(8'h05, 8'h23);
        host_wr(8'h7F, 8'h05);
        sim_rd(7'h7F);          check("t2_sim_index", ram_rdata, 8'h05);
        sim_rd(7'h05);          check("t2_sim_table", ram_rdata, 8'h23);
        idle(2);                check("t2_hold", ram_rdata, 8'h23);

        // Same-cycle host write and sim read of one word
        host_wr(8'h09, 8'h40);
        cycle_op(1'b1, 1'b0, 8'h09, 8'h11, 1'b1, 7'h09);
        check("t3_read_old", ram_rdata, 8'h40);
        sim_rd(7'h09);          check("t3_read_new", ram_rdata, 8'h11);

        // Index 127 stored as written
        host_wr(8'h7F, 8'h7F);  check("idx_unclamped", cur_index, 7'h7F);
        sim_rd(7'h7F);          check("idx_unclamped_sim", ram_rdata, 8'h7F);

        // Wrapping sweep, LIMIT=3, DWELL=2
        host_wr(8'h81, 8'd3);
        host_wr(8'h84, 8'd2);
        host_wr(8'h85, 8'd0);
        host_wr(8'h86, 8'd0);
        host_wr(8'h80, 8'h07);  check("t4_k0", cur_index, 7'd0);
        idle(3);                check("t4_k3", cur_index, 7'd1);
        idle(6);                check("t4_k9", cur_index, 7'd3);
        idle(3);                check("t4_k12_wrap", cur_index, 7'd0);
        check("t4_no_done", sweep_done, 1'b0);

        // One-shot sweep, restarted while running
        host_wr(8'h80, 8'h05);  check("t5_restart", cur_index, 7'd0);
        idle(14);               check("t5_stop_idx", cur_index, 7'd3);
        check("t5_done", sweep_done, 1'b1);
        host_rd(8'h88);         check("t5_status", host_readdata, 8'h02);
        host_wr(8'h7F, 8'h07);  check("t5_idx_wr", cur_index, 7'd7);
        check("t5_done_clr", sweep_done, 1'b0);
        host_rd(8'h88);         check("t5_status_clr", host_readdata, 8'h00);
        host_wr(8'h80, 8'h00);

        // Reset mid-sweep with a host read in flight
        host_wr(8'h80, 8'h07);
        idle(6);
        host_rd(8'h05);
        check("t6_pre_idx", cur_index, 7'd2);
        check("t6_pre_rvalid", host_rvalid, 1'b1);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_rvalid", host_rvalid, 1'b0);
        check("t6_idx", cur_index, 7'd0);
        check("t6_done", sweep_done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        host_rd(8'h05);         check("t6_table_kept", host_readdata, 8'h23);
        host_rd(8'h88);         check("t6_status_idle", host_readdata, 8'h00);
        host_rd(8'h80);         check("t6_ctrl", host_readdata, 8'h00);
        host_rd(8'h81);         check("t6_limit", host_readdata, 8'd126);
        host_rd(8'h84);         check("t6_dwell", host_readdata, 8'h00);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
